// File: rtl/beidou_parse_sched.sv
// rtl/beidou_parse_sched.sv - round-robin scheduler for the shared BeiDou shift/parse datapath
//
// Grants the single navigation-message parser to one of N_CH channels at a time.
// Each window holds shift_parse high for WIN_LEN cycles, then a GAP_LEN idle guard follows.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   req          per-channel one-cycle request pulse (frame delay expired)
//   abort        terminate the current window (ignored outside SHIFT)
//   grant        one-hot parser owner, zero outside SHIFT
//   grant_id     binary owner index, held from the last window while idle
//   shift_parse  parser shift enable, high for the whole window
//   busy         high in SHIFT or GAP
//   win_done     one-cycle pulse, window completed normally
//   win_abort    one-cycle pulse, window cut short by abort
//   req_ovf      one-cycle pulse, request hit an already pending channel
module beidou_parse_sched #(
    parameter int N_CH    = 4,
    parameter int WIN_LEN = 3052,
    parameter int GAP_LEN = 4,
    parameter int CNT_W   = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] req,
    input  logic            abort,
    output logic [N_CH-1:0] grant,
    output logic [2:0]      grant_id,
    output logic            shift_parse,
    output logic            busy,
    output logic            win_done,
    output logic            win_abort,
    output logic            req_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [N_CH-1:0] pending, pending_nx, clr;
    logic [2:0]      last, last_nx;

    logic [N_CH-1:0] grant_d;
    logic [2:0]      grant_id_d;
    logic            shift_d, busy_d, done_d, abort_d, ovf_d;

    logic [2:0]      winner;
    logic            found;
    logic [N_CH-1:0] win_onehot;
    logic [3:0]      sum;
    logic [N_CH-1:0] hit;

    logic win_end, gap_end;

    // Search pending starting just after the previous owner so every channel
    // gets a turn before any channel is served twice.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        hit    = '0;
        for (int i = 1; i <= N_CH; i++) begin
            sum = {1'b0, last} + 4'(i);
            if (sum >= 4'(N_CH)) begin
                sum = sum - 4'(N_CH);
            end
            hit = pending >> sum;
            if (!found && hit[0]) begin
                found  = 1'b1;
                winner = sum[2:0];
            end
        end
        win_onehot = N_CH'(1) << winner;
    end

    assign win_end = (state == SHIFT) && (abort || (cnt == CNT_W'(WIN_LEN)));
    // GAP is entered with cnt=0, so the last guard cycle is GAP_LEN-1.
    assign gap_end = (state == GAP) && (cnt == CNT_W'(GAP_LEN - 1));

    // State register plus the registered outputs and datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            pending     <= '0;
            last        <= 3'(N_CH - 1);
            grant       <= '0;
            grant_id    <= '0;
            shift_parse <= 1'b0;
            busy        <= 1'b0;
            win_done    <= 1'b0;
            win_abort   <= 1'b0;
            req_ovf     <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            pending     <= pending_nx;
            last        <= last_nx;
            grant       <= grant_d;
            grant_id    <= grant_id_d;
            shift_parse <= shift_d;
            busy        <= busy_d;
            win_done    <= done_d;
            win_abort   <= abort_d;
            req_ovf     <= ovf_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = SHIFT;
            SHIFT:   if (win_end) state_nx = (GAP_LEN == 0) ? IDLE : GAP;
            GAP:     if (gap_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output / datapath next values; everything lands in registers above.
    always_comb begin
        grant_d    = '0;
        grant_id_d = grant_id;
        shift_d    = 1'b0;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        ovf_d      = |(req & pending);
        busy_d     = (state_nx != IDLE);
        cnt_nx     = '0;
        clr        = '0;
        last_nx    = last;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_d    = win_onehot;
                    grant_id_d = winner;
                    shift_d    = 1'b1;
                    cnt_nx     = CNT_W'(1);
                    clr        = win_onehot;
                    last_nx    = winner;
                end
            end
            SHIFT: begin
                if (win_end) begin
                    done_d  = !abort;
                    abort_d = abort;
                end else begin
                    grant_d = grant;
                    shift_d = 1'b1;
                    cnt_nx  = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (!gap_end) cnt_nx = cnt + CNT_W'(1);
            end
            default: ;
        endcase
        // A request on the clear edge re-pends the channel: set wins.
        pending_nx = (pending & ~clr) | req;
    end

endmodule

// File: tb/tb_beidou_parse_sched.sv
// tb/tb_beidou_parse_sched.sv - scoreboard bench for beidou_parse_sched
`timescale 1ns/1ps
module tb_beidou_parse_sched;

    localparam int N_CH = 4;
    localparam int WIN  = 3052;
    localparam int GAP  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       abort = 1'b0;
    logic [3:0] grant;
    logic [2:0] grant_id;
    logic       shift_parse, busy, win_done, win_abort, req_ovf;

    beidou_parse_sched #(.N_CH(N_CH), .WIN_LEN(WIN), .GAP_LEN(GAP), .CNT_W(12)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .abort       (abort),
        .grant       (grant),
        .grant_id    (grant_id),
        .shift_parse (shift_parse),
        .busy        (busy),
        .win_done    (win_done),
        .win_abort   (win_abort),
        .req_ovf     (req_ovf)
    );

    always #5 clk = ~clk;

    // kind: 0 normal completion, 1 aborted, 2 killed by reset
    typedef struct {
        int id;
        int len;
        int kind;
        bit b2b;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_cyc = 0;
    int   onehot_err = 0;
    bit   in_win = 1'b0;
    logic prev_sp = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Window monitor: pops the expected owner at each shift_parse rise and
    // checks length and termination kind when the window closes.
    always @(negedge clk) begin
        if (!rst_n) begin
            if (in_win) begin
                check("win_killed_by_reset", cur.kind, 2);
                in_win = 1'b0;
            end
            prev_sp = 1'b0;
        end else begin
            if (shift_parse && !prev_sp) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_window", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("grant_id", grant_id, cur.id);
                    check("grant", grant, 32'(1) << cur.id);
                    if (cur.b2b) check("b2b_spacing", cyc - done_cyc, GAP + 1);
                    start_cyc = cyc;
                    in_win    = 1'b1;
                end
            end
            if (shift_parse && in_win && (32'(grant) != (32'(1) << cur.id))) onehot_err++;
            if (!shift_parse && grant != 4'b0) onehot_err++;
            if (win_done || win_abort) begin
                if (!in_win) begin
                    check("stray_window_end", 1, 0);
                end else begin
                    check("end_kind", {win_abort, win_done}, (cur.kind == 1) ? 2 : 1);
                    check("win_len", cyc - start_cyc, cur.len);
                end
                done_cyc = cyc;
                in_win   = 1'b0;
            end
            prev_sp = shift_parse;
        end
    end

    task automatic pulse(input logic [3:0] v);
        req = v;
        @(posedge clk);
        #1;
        req = '0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        bit ok = 1'b0;
        while (k < budget && !ok) begin
            @(negedge clk);
            k++;
            ok = !busy && !shift_parse && (exp_q.size() == 0) && !in_win;
        end
        check("idle_reached", ok, 1);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!win_done && k < budget);
        check("done_reached", win_done, 1);
    endtask

    task automatic wait_sp(input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!shift_parse && k < budget);
        check("sp_reached", shift_parse, 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_sp", shift_parse, 0);
        check("rst_busy", busy, 0);
        check("rst_done", win_done, 0);
        check("rst_abort", win_abort, 0);
        check("rst_ovf", req_ovf, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Single request: exact latency and window timing.
        exp_q.push_back('{0, WIN, 0, 1'b0});
        pulse(4'b0001);
        @(negedge clk);
        check("t1_sp_c1", shift_parse, 0);
        check("t1_busy_c1", busy, 0);
        @(negedge clk);
        check("t1_sp_c2", shift_parse, 1);
        check("t1_grant_c2", grant, 4'b0001);
        check("t1_busy_c2", busy, 1);
        repeat (WIN - 1) @(negedge clk);
        check("t1_sp_last", shift_parse, 1);
        @(negedge clk);
        check("t1_sp_fall", shift_parse, 0);
        check("t1_done", win_done, 1);
        check("t1_busy_gap", busy, 1);
        repeat (GAP - 1) @(negedge clk);
        check("t1_busy_gap_end", busy, 1);
        @(negedge clk);
        check("t1_busy_low", busy, 0);
        wait_idle(100);

        // Simultaneous requests on ch1 and ch3, served back to back.
        @(posedge clk); #1;
        exp_q.push_back('{1, WIN, 0, 1'b0});
        exp_q.push_back('{3, WIN, 0, 1'b1});
        pulse(4'b1010);
        wait_idle(20000);

        // Fairness: all four request, ch0 re-requests during its own window.
        @(posedge clk); #1;
        exp_q.push_back('{0, WIN, 0, 1'b0});
        exp_q.push_back('{1, WIN, 0, 1'b1});
        exp_q.push_back('{2, WIN, 0, 1'b1});
        exp_q.push_back('{3, WIN, 0, 1'b1});
        exp_q.push_back('{0, WIN, 0, 1'b1});
        pulse(4'b1111);
        wait_sp(10);
        @(posedge clk); #1;
        pulse(4'b0001);
        wait_idle(20000);

        // Abort on ch2 at counter 100, then pending ch0 is served.
        @(posedge clk); #1;
        exp_q.push_back('{2, 100, 1, 1'b0});
        exp_q.push_back('{0, WIN, 0, 1'b1});
        pulse(4'b0101);
        repeat (100) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("t4_sp_low", shift_parse, 0);
        check("t4_win_abort", win_abort, 1);
        check("t4_win_done", win_done, 0);
        check("t4_busy", busy, 1);
        wait_idle(10000);
        @(posedge clk); #1 abort = 1'b1;
        repeat (3) @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("t4_idle_abort_pulse", win_abort, 0);
        check("t4_idle_abort_busy", busy, 0);

        // Overflow: ch0 waits behind ch1 and is requested three times.
        @(posedge clk); #1;
        exp_q.push_back('{1, WIN, 0, 1'b0});
        exp_q.push_back('{0, WIN, 0, 1'b1});
        exp_q.push_back('{0, WIN, 0, 1'b1});
        pulse(4'b0010);
        repeat (20) @(posedge clk);
        #1;
        pulse(4'b0001);
        @(negedge clk);
        check("t5_ovf_first", req_ovf, 0);
        @(posedge clk); #1;
        pulse(4'b0001);
        @(negedge clk);
        check("t5_ovf_second", req_ovf, 1);
        @(negedge clk);
        check("t5_ovf_clears", req_ovf, 0);
        @(posedge clk); #1;
        pulse(4'b0001);
        @(negedge clk);
        check("t5_ovf_third", req_ovf, 1);
        wait_done(4000);
        repeat (GAP) @(posedge clk);
        #1;
        pulse(4'b0001);
        @(negedge clk);
        check("t5_clear_edge_ovf", req_ovf, 1);
        check("t5_clear_edge_sp", shift_parse, 1);
        wait_idle(10000);
        repeat (10) @(negedge clk);
        check("t5_no_extra_window", busy, 0);

        // Reset at counter 1500 on ch2 with ch3 pending.
        @(posedge clk); #1;
        exp_q.push_back('{2, 0, 2, 1'b0});
        pulse(4'b0100);
        pulse(4'b1000);
        repeat (1499) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_sp", shift_parse, 0);
        check("t6_rst_grant", grant, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", win_done, 0);
        check("t6_rst_abort", win_abort, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_pending_cleared", busy, 0);
        check("t6_no_sp", shift_parse, 0);
        @(posedge clk); #1;
        exp_q.push_back('{1, WIN, 0, 1'b0});
        pulse(4'b0010);
        @(negedge clk);
        check("t6_sp_c1", shift_parse, 0);
        @(negedge clk);
        check("t6_sp_c2", shift_parse, 1);
        check("t6_grant_c2", grant, 4'b0010);
        wait_idle(5000);

        check("onehot_violations", onehot_err, 0);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
